uart_rx_ctrl: RTL and testbench

//  UART receive controller. It drives enable_count into the edge/bit counter and consumes that counter's edge_cnt and bit_cnt outputs.
//  It samples rx_in, deserialises LSB-first data, checks parity and the stop bit, and emits a parallel byte with a one-cycle valid.

---
 rtl/uart_rx_pkg.sv | 18 +
 rtl/uart_rx_sampler.sv | 58 +++++
 rtl/uart_rx_ctrl.sv | 130 +++++++++++++
 tb/tb_uart_rx_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive controller.
//   rx_state_e : controller states (IDLE, START, DATA, PARITY, STOP)
//   PAR_EVEN / PAR_ODD : encodings of the par_typ input
`timescale 1ns/1ps
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_sampler.sv
// Mid-bit sampler for the UART receiver.
//   clk, rst      : clock, async active-low reset
//   rx_in         : synchronised serial line
//   prescale      : oversampling ratio
//   edge_cnt      : position inside the current bit
//   enable        : frame in progress; captures are gated off otherwise
//   sampled       : registered bit decision, stable before bit_end
// Build option UART_RX_MAJORITY_EN: majority of three samples around mid-bit
// (edge_cnt = prescale/2-1, prescale/2, prescale/2+1); otherwise a single
// sample at edge_cnt = prescale/2.
`timescale 1ns/1ps
module uart_rx_sampler #(
  parameter int unsigned PRESC_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_in,
  input  logic [PRESC_W-1:0] prescale,
  input  logic [PRESC_W-1:0] edge_cnt,
  input  logic               enable,
  output logic               sampled
);

  logic [PRESC_W-1:0] w_mid;
  logic               r_sampled;

  assign w_mid   = prescale >> 1;
  assign sampled = r_sampled;

`ifdef UART_RX_MAJORITY_EN
  logic r_s0;
  logic r_s1;

  // First two samples are held; the third is voted in directly from rx_in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s0      <= 1'b0;
      r_s1      <= 1'b0;
      r_sampled <= 1'b0;
    end else if (enable) begin
      if (edge_cnt == w_mid - PRESC_W'(1)) r_s0 <= rx_in;
      if (edge_cnt == w_mid)               r_s1 <= rx_in;
      if (edge_cnt == w_mid + PRESC_W'(1))
        r_sampled <= (r_s0 & r_s1) | (r_s0 & rx_in) | (r_s1 & rx_in);
    end
  end
`else
  // Single capture in the middle of the bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sampled <= 1'b0;
    end else if (enable && (edge_cnt == w_mid)) begin
      r_sampled <= rx_in;
    end
  end
`endif

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: frame state machine, LSB-first deserialiser,
// parity and stop-bit checks, registered byte output with one-cycle valid.
//   clk, rst      : clock, async active-low reset
//   rx_in         : synchronised serial line, idle high
//   prescale      : oversampling ratio (8/16/32)
//   par_en/par_typ: parity present / 0 even, 1 odd (latched at frame start)
//   edge_cnt,bit_cnt : position from the external edge/bit counter
//   enable_count  : counter enable, low clears the counter
//   p_data        : last good byte
//   data_valid    : one-cycle pulse when p_data updates
//   par_err/stp_err : error flags, held until the next frame start
// Build option UART_RX_MAJORITY_EN selects 3-sample majority voting in the
// sampler; latency is the same either way.
`timescale 1ns/1ps
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESC_W    = 6,
  parameter int unsigned BITCNT_W   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic [PRESC_W-1:0]    prescale,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic [PRESC_W-1:0]    edge_cnt,
  input  logic [BITCNT_W-1:0]   bit_cnt,
  output logic                  enable_count,
  output logic [DATA_WIDTH-1:0] p_data,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  rx_state_e             r_state;
  rx_state_e             w_next;
  logic                  w_bit_end;
  logic                  w_sampled;
  logic                  w_start_entry;
  logic                  w_exp_par;
  logic                  r_enable;
  logic                  r_par_en;
  logic                  r_par_typ;
  logic                  r_par_err;
  logic                  r_stp_err;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_shreg;
  logic [DATA_WIDTH-1:0] r_p_data;

  assign w_bit_end     = (edge_cnt == prescale - PRESC_W'(1));
  assign w_start_entry = (r_state == IDLE) && (w_next == START);
  assign w_exp_par     = (^r_shreg) ^ (r_par_typ == PAR_ODD);

  uart_rx_sampler #(.PRESC_W(PRESC_W)) u_sampler (
    .clk      (clk),
    .rst      (rst),
    .rx_in    (rx_in),
    .prescale (prescale),
    .edge_cnt (edge_cnt),
    .enable   (r_enable),
    .sampled  (w_sampled)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic; every transition out of a bit state waits for bit_end.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:   if (!rx_in) w_next = START;
      START:  if (w_bit_end) w_next = w_sampled ? IDLE : DATA;
      DATA:   if (w_bit_end && (bit_cnt == BITCNT_W'(DATA_WIDTH)))
                w_next = r_par_en ? PARITY : STOP;
      PARITY: if (w_bit_end) w_next = STOP;
      STOP:   if (w_bit_end) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_enable  <= 1'b0;
      r_par_en  <= 1'b0;
      r_par_typ <= 1'b0;
      r_par_err <= 1'b0;
      r_stp_err <= 1'b0;
      r_valid   <= 1'b0;
      r_shreg   <= '0;
      r_p_data  <= '0;
    end else begin
      r_valid  <= 1'b0;
      // Registered copy of (state != IDLE), tracking the state register.
      r_enable <= (w_next != IDLE);
      if (w_start_entry) begin
        r_par_en  <= par_en;
        r_par_typ <= par_typ;
        r_par_err <= 1'b0;
        r_stp_err <= 1'b0;
      end
      if (w_bit_end) begin
        case (r_state)
          DATA:   r_shreg <= {w_sampled, r_shreg[DATA_WIDTH-1:1]};
          PARITY: r_par_err <= w_sampled ^ w_exp_par;
          STOP: begin
            r_stp_err <= ~w_sampled;
            if (!r_par_err && w_sampled) begin
              r_p_data <= r_shreg;
              r_valid  <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign enable_count = r_enable;
  assign p_data       = r_p_data;
  assign data_valid   = r_valid;
  assign par_err      = r_par_err;
  assign stp_err      = r_stp_err;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
`timescale 1ns/1ps
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic [5:0] prescale;
  logic       par_en;
  logic       par_typ;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       enable_count;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_rx_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .rx_in        (rx_in),
    .prescale     (prescale),
    .par_en       (par_en),
    .par_typ      (par_typ),
    .edge_cnt     (edge_cnt),
    .bit_cnt      (bit_cnt),
    .enable_count (enable_count),
    .p_data       (p_data),
    .data_valid   (data_valid),
    .par_err      (par_err),
    .stp_err      (stp_err)
  );

  // Edge/bit counter partner block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (!enable_count) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (edge_cnt == prescale - 6'd1) begin
      edge_cnt <= '0;
      bit_cnt  <= bit_cnt + 4'd1;
    end else begin
      edge_cnt <= edge_cnt + 6'd1;
    end
  end

  // Output monitor: frame length, valid latency, received bytes.
  int         cyc = 0;
  int         start_cyc = 0;
  int         last_len = -1;
  int         valid_lat = -1;
  logic       prev_en = 1'b0;
  logic [7:0] vq[$];

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!rst) begin
      prev_en = 1'b0;
    end else begin
      if (enable_count && !prev_en) start_cyc = cyc;
      if (!enable_count && prev_en) last_len = cyc - start_cyc;
      if (data_valid) begin
        vq.push_back(p_data);
        valid_lat = cyc - start_cyc;
      end
      prev_en = enable_count;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one frame, 8 clocks per bit; optional one-clock glitch at offset 5 of bit glitch_bit.
  task automatic send_frame(input logic [7:0] d, input logic pe, input logic pbit,
                            input logic stop, input int glitch_bit);
    logic bits [0:10];
    int   nb;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
    nb = 9;
    if (pe) begin
      bits[nb] = pbit;
      nb++;
    end
    bits[nb] = stop;
    nb++;
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c < 8; c++) begin
        rx_in = (b == glitch_bit && c == 5) ? ~bits[b] : bits[b];
        tick(1);
      end
    end
    rx_in = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       pe;
    logic       pt;
    logic       pbit;
    logic       stop;
    logic       exp_valid;
    logic [7:0] exp_pdata;
    logic       exp_perr;
    logic       exp_serr;
    int         exp_len;
  } vec_t;

  vec_t vecs [0:6];
  int   glitch;

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 80};
    vecs[1] = '{8'h0F, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h0F, 1'b0, 1'b0, 88};
    vecs[2] = '{8'h0F, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h0F, 1'b1, 1'b0, 88};
    vecs[3] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0F, 1'b0, 1'b1, 80};
    vecs[4] = '{8'h81, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h81, 1'b0, 1'b0, 88};
    vecs[5] = '{8'h6E, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1, 88};
    vecs[6] = '{8'h07, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h81, 1'b1, 1'b0, 88};

    rst = 1'b0;
    rx_in = 1'b1;
    prescale = 6'd8;
    par_en = 1'b0;
    par_typ = 1'b0;
    tick(3);
    chk("rst_enable", {31'd0, enable_count}, 32'd0);
    chk("rst_pdata", {24'd0, p_data}, 32'd0);
    chk("rst_valid", {31'd0, data_valid}, 32'd0);
    chk("rst_flags", {30'd0, par_err, stp_err}, 32'd0);
    rst = 1'b1;
    tick(5);
    chk("idle_enable", {31'd0, enable_count}, 32'd0);

    // Table-driven frames.
    for (int v = 0; v < 7; v++) begin
      vq.delete();
      last_len = -1;
      valid_lat = -1;
      par_en = vecs[v].pe;
      par_typ = vecs[v].pt;
      send_frame(vecs[v].data, vecs[v].pe, vecs[v].pbit, vecs[v].stop, -1);
      // Config changes after the frame must not matter.
      par_en = ~par_en;
      par_typ = ~par_typ;
      tick(6);
      chk($sformatf("v%0d_valid_cnt", v), 32'(vq.size()), {31'd0, vecs[v].exp_valid});
      if (vq.size() > 0) begin
        chk($sformatf("v%0d_valid_data", v), {24'd0, vq[0]}, {24'd0, vecs[v].exp_pdata});
        chk($sformatf("v%0d_valid_lat", v), 32'(valid_lat), 32'(vecs[v].exp_len));
      end
      chk($sformatf("v%0d_pdata", v), {24'd0, p_data}, {24'd0, vecs[v].exp_pdata});
      chk($sformatf("v%0d_par_err", v), {31'd0, par_err}, {31'd0, vecs[v].exp_perr});
      chk($sformatf("v%0d_stp_err", v), {31'd0, stp_err}, {31'd0, vecs[v].exp_serr});
      chk($sformatf("v%0d_frame_len", v), 32'(last_len), 32'(vecs[v].exp_len));
      chk($sformatf("v%0d_idle", v), {31'd0, enable_count}, 32'd0);
    end

    // False start: line low for 2 clocks only.
    vq.delete();
    last_len = -1;
    rx_in = 1'b0;
    tick(2);
    rx_in = 1'b1;
    tick(14);
    chk("glitch_len", 32'(last_len), 32'd8);
    chk("glitch_valid_cnt", 32'(vq.size()), 32'd0);
    chk("glitch_flags", {30'd0, par_err, stp_err}, 32'd0);
    chk("glitch_pdata", {24'd0, p_data}, 32'h81);

    // Back-to-back frames; majority build also gets a mid-sample glitch.
`ifdef UART_RX_MAJORITY_EN
    glitch = 3;
`else
    glitch = -1;
`endif
    vq.delete();
    par_en = 1'b0;
    send_frame(8'h55, 1'b0, 1'b0, 1'b1, glitch);
    send_frame(8'hAA, 1'b0, 1'b0, 1'b1, -1);
    tick(8);
    chk("b2b_count", 32'(vq.size()), 32'd2);
    if (vq.size() == 2) begin
      chk("b2b_first", {24'd0, vq[0]}, 32'h55);
      chk("b2b_second", {24'd0, vq[1]}, 32'hAA);
    end
    chk("b2b_flags", {30'd0, par_err, stp_err}, 32'd0);

    // Reset in the middle of the data bits.
    vq.delete();
    rx_in = 1'b0;
    tick(8);
    rx_in = 1'b1;
    tick(8);
    rx_in = 1'b0;
    tick(8);
    rx_in = 1'b1;
    tick(10);
    chk("pre_rst_busy", {31'd0, enable_count}, 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_enable", {31'd0, enable_count}, 32'd0);
    chk("mid_rst_pdata", {24'd0, p_data}, 32'd0);
    chk("mid_rst_outs", {29'd0, data_valid, par_err, stp_err}, 32'd0);
    tick(2);
    rst = 1'b1;
    tick(20);
    chk("post_rst_idle", {31'd0, enable_count}, 32'd0);
    chk("post_rst_valid_cnt", 32'(vq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
